// File: rtl/sblk_pkg.sv
// Shared definitions for the superblock-row instruction scheduler.
//   - Instruction field widths (TN, TM, TP, LN, LP) and the derived WID_INST.
//   - N_ROW: number of superblock rows driven by one scheduler.
//   - sched_entry_t: one buffered instruction {barrier, mask, inst}.
//   - sched_state_e: scheduler FSM states.
//   - can_issue(): issue rule for the head entry.
package sblk_pkg;

  localparam int WID_INST_TN = 3;
  localparam int WID_INST_TM = 3;
  localparam int WID_INST_TP = 3;
  localparam int WID_INST_LN = 3;
  localparam int WID_INST_LP = 2;
  localparam int WID_INST    = WID_INST_TN + WID_INST_TM + WID_INST_TP +
                               WID_INST_LN + WID_INST_LP;

  localparam int N_ROW = 8;

  typedef struct packed {
    logic             barrier;
    logic [N_ROW-1:0] mask;
    logic [WID_INST-1:0] inst;
  } sched_entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_WAIT  = 2'd2,
    S_ISSUE = 2'd3
  } sched_state_e;

  // A barrier waits for the whole row set to drain; an ordinary entry only
  // needs its own target rows free. An empty mask is always issuable unless
  // it is a barrier.
  function automatic logic can_issue(
    input logic             barrier,
    input logic [N_ROW-1:0] mask,
    input logic [N_ROW-1:0] busy
  );
    if (barrier) begin
      return (busy == '0);
    end
    return ((busy & mask) == '0);
  endfunction

endpackage

// File: rtl/sched_fifo.sv
// Small synchronous FIFO used to buffer scheduler instructions.
// Ports:
//   clk_l, rst_n  clock, asynchronous active-low reset (clears pointers/count)
//   push, wdata   write request and data (ignored when full)
//   pop           read request (ignored when empty)
//   rdata         head entry, valid whenever empty is low
//   count         number of entries held (0..DEPTH)
//   full, empty   occupancy flags
module sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_l,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset: stale contents are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk_l) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/sblk_row_inst_sched.sv
// In-order instruction scheduler for a row of superblocks.
// Buffers {barrier, mask, inst} from the layer controller and issues the
// head entry to its target rows once they are idle.
// Ports:
//   clk_l, rst_n   scheduler clock, asynchronous active-low reset
//   in_vld/in_rdy  instruction handshake; in_rdy low when the FIFO is full
//   in_inst        instruction word
//   in_mask        destination rows (bit r = row r)
//   in_barrier     issue only when every row is idle and nothing outstanding
//   status_sblk    per-row busy status from the superblocks
//   inst_data      per-row instruction, slice r = [r*WID_INST +: WID_INST]
//   inst_en        one-cycle issue strobe per row
//   fifo_cnt       entries buffered
//   all_idle       FIFO empty, no row busy, no lock held
//   issue_cnt      issued instructions (wrapping, empty masks not counted)
// Row count and instruction width come from sblk_pkg.
module sblk_row_inst_sched
  import sblk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk_l,
  input  logic                      rst_n,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [WID_INST-1:0]       in_inst,
  input  logic [N_ROW-1:0]          in_mask,
  input  logic                      in_barrier,
  input  logic [N_ROW-1:0]          status_sblk,
  output logic [WID_INST*N_ROW-1:0] inst_data,
  output logic [N_ROW-1:0]          inst_en,
  output logic [$clog2(DEPTH):0]    fifo_cnt,
  output logic                      all_idle,
  output logic [15:0]               issue_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  sched_state_e              state_q, state_d;
  logic [N_ROW-1:0]          inst_en_q, inst_en_d;
  logic [WID_INST*N_ROW-1:0] inst_data_q, inst_data_d;
  logic [N_ROW-1:0]          lock_q, lock_d;
  logic [N_ROW-1:0]          status_q;
  logic [15:0]               issue_cnt_q, issue_cnt_d;
  logic                      all_idle_q, all_idle_d;

  sched_entry_t     wr_entry;
  sched_entry_t     head;
  logic             push, pop;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    cnt_nxt;
  logic [N_ROW-1:0] busy;

  assign wr_entry = '{barrier: in_barrier, mask: in_mask, inst: in_inst};
  assign push     = in_vld & ~fifo_full;

  sched_fifo #(
    .WIDTH ($bits(sched_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_l (clk_l),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The lock covers the cycles between our strobe and the sblk raising its
  // status, so a row is never issued twice before it reports busy.
  assign busy = status_q | lock_q;

  always_comb begin
    state_d     = state_q;
    inst_en_d   = '0;
    inst_data_d = '0;
    lock_d      = lock_q & ~status_sblk;
    issue_cnt_d = issue_cnt_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK, S_WAIT: begin
        if (can_issue(head.barrier, head.mask, busy)) begin
          state_d   = S_ISSUE;
          pop       = 1'b1;
          inst_en_d = head.mask;
          for (int r = 0; r < N_ROW; r++) begin
            if (head.mask[r]) begin
              inst_data_d[r*WID_INST +: WID_INST] = head.inst;
            end
          end
          // A new issue wins over a clear from a stale status pulse.
          lock_d = lock_d | head.mask;
          if (head.mask != '0) begin
            issue_cnt_d = issue_cnt_q + 16'd1;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ISSUE: begin
        state_d = fifo_empty ? S_IDLE : S_CHECK;
      end
      default: state_d = S_IDLE;
    endcase
    cnt_nxt    = fifo_cnt + CW'(push) - CW'(pop);
    all_idle_d = (cnt_nxt == '0) && (status_sblk == '0) && (lock_d == '0);
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      inst_en_q   <= '0;
      inst_data_q <= '0;
      lock_q      <= '0;
      status_q    <= '0;
      issue_cnt_q <= '0;
      all_idle_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      inst_en_q   <= inst_en_d;
      inst_data_q <= inst_data_d;
      lock_q      <= lock_d;
      status_q    <= status_sblk;
      issue_cnt_q <= issue_cnt_d;
      all_idle_q  <= all_idle_d;
    end
  end

  assign in_rdy    = ~fifo_full;
  assign inst_en   = inst_en_q;
  assign inst_data = inst_data_q;
  assign issue_cnt = issue_cnt_q;
  assign all_idle  = all_idle_q;

endmodule
